dac_update_sched: RTL and testbench

DAC_UPDATE_SCHED -- requirements
Module: dac_update_sched

---
 rtl/dac_update_sched.sv | 177 +++++++++++++++++
 tb/tb_dac_update_sched.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_update_sched.sv
// dac_update_sched
// Paces SPI DAC updates from a free-running sample tick. On each tick one of
// two requesters is granted round-robin, its A/B codes are latched for the
// DAC driver, start is held for a fixed number of cycles, and the block then
// waits for done (bounded by a timeout) before acknowledging the requester.
module dac_update_sched #(
   parameter int SAMPLE_DIV   = 2500,
   parameter int START_HOLD   = 8,
   parameter int DONE_TIMEOUT = 4096
) (
   input  logic        sys_clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        req1,
   input  logic [11:0] data0_a,
   input  logic [11:0] data0_b,
   input  logic [11:0] data1_a,
   input  logic [11:0] data1_b,
   output logic        ack0,
   output logic        ack1,
   output logic [11:0] dac_in1,
   output logic [11:0] dac_in2,
   output logic        start,
   input  logic        done,
   output logic        busy,
   output logic        grant_id,
   output logic        overrun,
   output logic        timeout_err,
   input  logic        clr_err
);

   localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int HW = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;
   localparam int WW = $clog2(DONE_TIMEOUT + 1);

   localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(START_HOLD - 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'(DONE_TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   tick_cnt;
   logic            tick;
   logic [HW-1:0]   hold_q, hold_d;
   logic [WW-1:0]   wait_q, wait_d;
   logic            last_grant;
   logic            any_req;
   logic            grant_sel;
   logic            load;
   logic            ack_fire;
   logic            to_set;

   // Sample-rate divider; free-runs independent of the transfer state so the
   // update rate never drifts with DAC latency.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst)
         tick_cnt <= '0;
      else if (tick_cnt == TICK_LAST)
         tick_cnt <= '0;
      else
         tick_cnt <= tick_cnt + 1'b1;
   end

   assign tick = (tick_cnt == TICK_LAST);

   // Round-robin pick: on contention favour the requester not served last;
   // otherwise whoever is asking (req1 alone selects 1, req0 alone selects 0).
   always_comb begin
      any_req   = req0 | req1;
      grant_sel = (req0 & req1) ? ~last_grant : req1;
   end

   // FSM state and phase counters.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         hold_q  <= '0;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         wait_q  <= wait_d;
      end
   end

   // Next-state logic: grant on tick, hold start, then wait for done or timeout.
   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      wait_d   = wait_q;
      load     = 1'b0;
      ack_fire = 1'b0;
      to_set   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (tick && any_req) begin
               state_d = S_START;
               hold_d  = '0;
               load    = 1'b1;
            end
         end
         S_START: begin
            // done is deliberately not looked at here; a stale done from the
            // driver must not cut the start pulse short.
            if (hold_q == HOLD_LAST) begin
               state_d = S_WAIT;
               wait_d  = '0;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         S_WAIT: begin
            if (done) begin
               ack_fire = 1'b1;
               state_d  = S_IDLE;
            end else if (wait_q == WAIT_LAST) begin
               to_set  = 1'b1;
               state_d = S_IDLE;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Latch the granted codes and owner; they persist until the next grant.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         dac_in1  <= '0;
         dac_in2  <= '0;
         grant_id <= 1'b0;
      end else if (load) begin
         dac_in1  <= grant_sel ? data1_a : data0_a;
         dac_in2  <= grant_sel ? data1_b : data0_b;
         grant_id <= grant_sel;
      end
   end

   // Round-robin history only advances on a completed transfer, so a timed
   // out requester keeps priority and is retried on the next tick.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst)
         last_grant <= 1'b1;
      else if (ack_fire)
         last_grant <= grant_id;
   end

   // Sticky error flags; a set event in the same cycle as clr_err wins.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         overrun     <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         overrun     <= (tick & (state_q != S_IDLE)) | (overrun & ~clr_err);
         timeout_err <= to_set | (timeout_err & ~clr_err);
      end
   end

   // Status and handshake outputs decoded from the state register. The ack is
   // issued in the last WAIT cycle, so busy drops the cycle after it and the
   // requester can release req before the FSM is back in IDLE.
   always_comb begin
      start = (state_q == S_START);
      busy  = (state_q != S_IDLE);
      ack0  = ack_fire & ~grant_id;
      ack1  = ack_fire & grant_id;
   end

endmodule

// File: tb/tb_dac_update_sched.sv
// tb_dac_update_sched
// Scoreboard bench: each scenario queues the grant it expects (owner and
// codes); the transfer task pops it when the DUT raises start and checks the
// latch, start width, ack/timeout behaviour and flags.
module tb_dac_update_sched;

   localparam int SD = 100;
   localparam int SH = 8;
   localparam int DT = 120;

   logic        sys_clk = 1'b0;
   logic        rst;
   logic        req0, req1;
   logic [11:0] data0_a, data0_b, data1_a, data1_b;
   logic        ack0, ack1;
   logic [11:0] dac_in1, dac_in2;
   logic        start;
   logic        done;
   logic        busy;
   logic        grant_id;
   logic        overrun;
   logic        timeout_err;
   logic        clr_err;

   typedef struct packed {
      logic        id;
      logic [11:0] a;
      logic [11:0] b;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   dac_update_sched #(
      .SAMPLE_DIV   (SD),
      .START_HOLD   (SH),
      .DONE_TIMEOUT (DT)
   ) dut (
      .sys_clk     (sys_clk),
      .rst         (rst),
      .req0        (req0),
      .req1        (req1),
      .data0_a     (data0_a),
      .data0_b     (data0_b),
      .data1_a     (data1_a),
      .data1_b     (data1_b),
      .ack0        (ack0),
      .ack1        (ack1),
      .dac_in1     (dac_in1),
      .dac_in2     (dac_in2),
      .start       (start),
      .done        (done),
      .busy        (busy),
      .grant_id    (grant_id),
      .overrun     (overrun),
      .timeout_err (timeout_err),
      .clr_err     (clr_err)
   );

   always #5 sys_clk = ~sys_clk;

   function automatic void push_exp(input logic id, input logic [11:0] a, input logic [11:0] b);
      exp_t e;
      e.id = id;
      e.a  = a;
      e.b  = b;
      exp_q.push_back(e);
   endfunction

   // One full transfer as seen from the DAC driver side. lat = negedges waited
   // for start. give_done=0 lets the transfer time out.
   task automatic xfer(input int dly, input bit give_done, input bit early_done,
                       input bit drop, output int lat);
      exp_t e;
      int   n;
      bit   seen;
      lat  = 0;
      seen = 1'b0;
      while (start !== 1'b1 && lat < 3*SD) begin
         @(negedge sys_clk);
         lat++;
      end
      checks++;
      if (start !== 1'b1) begin
         failures++;
         $display("FAIL xfer_start: start=%b after %0d cycles, required 1", start, lat);
         return;
      end
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL xfer_scoreboard: grant id=%0d with nothing expected", grant_id);
         return;
      end
      e = exp_q.pop_front();
      checks++;
      if ({grant_id, dac_in1, dac_in2} !== e) begin
         failures++;
         $display("FAIL xfer_latch: got id=%0d a=%h b=%h, required id=%0d a=%h b=%h",
                  grant_id, dac_in1, dac_in2, e.id, e.a, e.b);
      end
      if (early_done) done = 1'b1;
      n = 0;
      while (start === 1'b1 && n < 4*SH + 4) begin
         @(negedge sys_clk);
         n++;
         if (n == 2) done = 1'b0;
      end
      checks++;
      if (n != SH) begin
         failures++;
         $display("FAIL start_width: got %0d cycles, required %0d", n, SH);
      end
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL wait_busy: busy=%b, required 1", busy);
      end
      // Requester data changes after latching must not reach the DAC.
      if (e.id) data1_a = ~data1_a; else data0_a = ~data0_a;
      if (give_done) begin
         repeat (dly) begin
            if (ack0 | ack1) seen = 1'b1;
            @(negedge sys_clk);
         end
         if (ack0 | ack1) seen = 1'b1;
         done = 1'b1;
         #1;
         checks++;
         if (seen) begin
            failures++;
            $display("FAIL early_ack: ack before done, required none");
         end
         checks++;
         if ({ack1, ack0} !== (e.id ? 2'b10 : 2'b01)) begin
            failures++;
            $display("FAIL ack: got ack1,ack0=%b%b, required owner %0d", ack1, ack0, e.id);
         end
         checks++;
         if ({dac_in1, dac_in2} !== {e.a, e.b}) begin
            failures++;
            $display("FAIL dac_hold: got a=%h b=%h, required a=%h b=%h", dac_in1, dac_in2, e.a, e.b);
         end
         if (drop) begin
            if (e.id) req1 = 1'b0; else req0 = 1'b0;
         end
         @(negedge sys_clk);
         done = 1'b0;
         checks++;
         if ({busy, ack1, ack0} !== 3'b000) begin
            failures++;
            $display("FAIL ack_end: busy,ack1,ack0=%b%b%b, required 000", busy, ack1, ack0);
         end
      end else begin
         n = 0;
         while (busy === 1'b1 && n < 3*DT) begin
            if (ack0 | ack1) seen = 1'b1;
            @(negedge sys_clk);
            n++;
         end
         checks++;
         if (n != DT) begin
            failures++;
            $display("FAIL timeout_len: WAIT lasted %0d cycles, required %0d", n, DT);
         end
         checks++;
         if (timeout_err !== 1'b1 || seen) begin
            failures++;
            $display("FAIL timeout_flag: timeout_err=%b ack_seen=%b, required 1 and 0", timeout_err, seen);
         end
      end
      if (e.id) data1_a = ~data1_a; else data0_a = ~data0_a;
   endtask

   task automatic test_reset();
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0; done = 1'b0; clr_err = 1'b0;
      data0_a = '0; data0_b = '0; data1_a = '0; data1_b = '0;
      repeat (3) @(negedge sys_clk);
      checks++;
      if ({start, ack0, ack1, busy, overrun, timeout_err, grant_id, dac_in1, dac_in2} !== '0) begin
         failures++;
         $display("FAIL reset_state: start=%b ack=%b%b busy=%b ovr=%b to=%b gid=%b dac=%h/%h, required all 0",
                  start, ack1, ack0, busy, overrun, timeout_err, grant_id, dac_in1, dac_in2);
      end
   endtask

   task automatic test_single();
      int lat;
      data0_a = 12'hABC; data0_b = 12'h123; req0 = 1'b1;
      push_exp(1'b0, 12'hABC, 12'h123);
      rst = 1'b0;
      xfer(20, 1'b1, 1'b1, 1'b1, lat);
      checks++;
      if (lat != SD) begin
         failures++;
         $display("FAIL first_grant: got %0d cycles after reset, required %0d", lat, SD);
      end
      checks++;
      if ({overrun, timeout_err} !== 2'b00) begin
         failures++;
         $display("FAIL single_flags: ovr=%b to=%b, required 00", overrun, timeout_err);
      end
   endtask

   task automatic test_round_robin();
      int lat;
      rst = 1'b1;
      repeat (2) @(negedge sys_clk);
      data0_a = 12'h111; data0_b = 12'h222; data1_a = 12'h333; data1_b = 12'h444;
      req0 = 1'b1; req1 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i[0]) push_exp(1'b1, 12'h333, 12'h444);
         else      push_exp(1'b0, 12'h111, 12'h222);
      end
      rst = 1'b0;
      for (int i = 0; i < 4; i++) xfer(5, 1'b1, 1'b0, (i == 3), lat);
      req0 = 1'b0; req1 = 1'b0;
   endtask

   task automatic test_timeout();
      int lat;
      req0 = 1'b1; req1 = 1'b1;
      push_exp(1'b0, 12'h111, 12'h222);
      xfer(0, 1'b0, 1'b0, 1'b0, lat);
      checks++;
      if (overrun !== 1'b1) begin
         failures++;
         $display("FAIL timeout_overrun: overrun=%b, required 1", overrun);
      end
      push_exp(1'b0, 12'h111, 12'h222);
      xfer(3, 1'b1, 1'b0, 1'b1, lat);
      checks++;
      if (lat != 2*SD - SH - DT) begin
         failures++;
         $display("FAIL retry_tick: retry after %0d cycles, required %0d", lat, 2*SD - SH - DT);
      end
      push_exp(1'b1, 12'h333, 12'h444);
      xfer(3, 1'b1, 1'b0, 1'b1, lat);
      clr_err = 1'b1;
      @(negedge sys_clk);
      clr_err = 1'b0;
      checks++;
      if ({overrun, timeout_err} !== 2'b00) begin
         failures++;
         $display("FAIL clr_err: ovr=%b to=%b, required 00", overrun, timeout_err);
      end
   endtask

   task automatic test_overrun();
      exp_t e;
      int   n;
      int   rises;
      logic prev;
      data0_a = 12'h5A5; data0_b = 12'hA5A; req0 = 1'b1;
      push_exp(1'b0, 12'h5A5, 12'hA5A);
      n = 0;
      while (start !== 1'b1 && n < 3*SD) begin
         @(negedge sys_clk);
         n++;
      end
      checks++;
      if (start !== 1'b1) begin
         failures++;
         $display("FAIL ovr_start: start=%b, required 1", start);
      end
      e = exp_q.pop_front();
      checks++;
      if ({grant_id, dac_in1, dac_in2} !== e) begin
         failures++;
         $display("FAIL ovr_latch: got id=%0d a=%h b=%h, required id=%0d a=%h b=%h",
                  grant_id, dac_in1, dac_in2, e.id, e.a, e.b);
      end
      rises = 1;
      prev  = start;
      for (int k = 1; k <= 260; k++) begin
         @(negedge sys_clk);
         if (start === 1'b1 && prev !== 1'b1) rises++;
         prev = start;
         if (k == 99) begin
            checks++;
            if (overrun !== 1'b0) begin
               failures++;
               $display("FAIL overrun_pre: overrun=%b, required 0", overrun);
            end
            clr_err = 1'b1;
         end
         if (k == 100) begin
            clr_err = 1'b0;
            checks++;
            if (overrun !== 1'b1) begin
               failures++;
               $display("FAIL overrun_set_wins: overrun=%b, required 1", overrun);
            end
         end
         if (k == 101) begin
            checks++;
            if (overrun !== 1'b1) begin
               failures++;
               $display("FAIL overrun_sticky: overrun=%b, required 1", overrun);
            end
         end
         if (k == SH + 105) begin
            done = 1'b1;
            #1;
            checks++;
            if ({ack1, ack0} !== 2'b01) begin
               failures++;
               $display("FAIL ovr_ack: ack1,ack0=%b%b, required 01", ack1, ack0);
            end
            req0 = 1'b0;
         end
         if (k == SH + 106) done = 1'b0;
      end
      checks++;
      if (rises != 1) begin
         failures++;
         $display("FAIL ovr_starts: got %0d start pulses, required 1", rises);
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      int   n;
      int   lat;
      data0_a = 12'h7E1; data0_b = 12'h1E7; req0 = 1'b1;
      push_exp(1'b0, 12'h7E1, 12'h1E7);
      push_exp(1'b0, 12'h7E1, 12'h1E7);
      n = 0;
      while (start !== 1'b1 && n < 3*SD) begin
         @(negedge sys_clk);
         n++;
      end
      e = exp_q.pop_front();
      checks++;
      if (start !== 1'b1 || {grant_id, dac_in1, dac_in2} !== e) begin
         failures++;
         $display("FAIL mid_grant: start=%b id=%0d a=%h b=%h, required 1 id=%0d a=%h b=%h",
                  start, grant_id, dac_in1, dac_in2, e.id, e.a, e.b);
      end
      n = 0;
      while (start === 1'b1 && n < 50) begin
         @(negedge sys_clk);
         n++;
      end
      repeat (5) @(negedge sys_clk);
      #2 rst = 1'b1;
      done = 1'b1;
      #1;
      checks++;
      if ({start, ack0, ack1, busy, overrun, timeout_err, grant_id, dac_in1, dac_in2} !== '0) begin
         failures++;
         $display("FAIL reset_async: start=%b ack=%b%b busy=%b ovr=%b to=%b gid=%b dac=%h/%h, required all 0",
                  start, ack1, ack0, busy, overrun, timeout_err, grant_id, dac_in1, dac_in2);
      end
      repeat (3) @(negedge sys_clk);
      done = 1'b0;
      rst  = 1'b0;
      xfer(10, 1'b1, 1'b0, 1'b1, lat);
      checks++;
      if (lat != SD) begin
         failures++;
         $display("FAIL reserve_after_reset: got %0d cycles, required %0d", lat, SD);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_timeout();
      test_overrun();
      test_reset_mid();
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_left: %0d expected grants never seen, required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
